// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: shares one single-port register file between two requesters.
// Round-robin arbitration by default; define RF_ARB_FIXED_PRIO_EN for fixed port-0 priority.
`timescale 1ns/1ps
// state | meaning
// IDLE  | no access in flight, ready asserted combinationally to the granted port
// ISSUE | latched access driven onto the register file
// WAIT  | extra cycle so a registered rf_dout can settle (RD_LAT=1 reads only)
// RESP  | one-cycle response pulse to the latched port
module reg_file_arbiter #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_reg_no,
    output logic [DATA_W-1:0] rf_val,
    input  logic [DATA_W-1:0] rf_dout,
    output logic              busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [1:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              port_q, port_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
`ifndef RF_ARB_FIXED_PRIO_EN
    logic              last_grant_q, last_grant_d;
`endif

    logic              in_range;
    logic              grant0, grant1;
    logic              sample;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
`ifdef RF_ARB_FIXED_PRIO_EN
        grant1 = req1_valid && !req0_valid;
`else
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
`endif
        grant0 = req0_valid && !grant1;
    end

    assign req0_ready = (state_q == S_IDLE) && grant0;
    assign req1_ready = (state_q == S_IDLE) && grant1;

    assign in_range = ({1'b0, reg_q} < NUM_REGS_W);
    // rf_dout is valid at the end of ISSUE for combinational files, at the end of WAIT otherwise
    assign sample   = (state_q == S_WAIT) ||
                      ((state_q == S_ISSUE) && !write_q && (RD_LAT == 0));
    assign rd_data  = in_range ? rf_dout : '0;

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        port_d       = port_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
`ifndef RF_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        if (sample) begin
            if (port_q) rsp1_rdata_d = rd_data;
            else        rsp0_rdata_d = rd_data;
        end
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    write_d = grant1 ? req1_write : req0_write;
                    reg_d   = grant1 ? req1_reg   : req0_reg;
                    wdata_d = grant1 ? req1_wdata : req0_wdata;
                    port_d  = grant1;
`ifndef RF_ARB_FIXED_PRIO_EN
                    last_grant_d = grant1;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (write_q)          state_d = S_IDLE;
                else if (RD_LAT == 0) state_d = S_RESP;
                else                  state_d = S_WAIT;
            end
            S_WAIT:  state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            reg_q        <= '0;
            wdata_q      <= '0;
            port_q       <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            reg_q        <= reg_d;
            wdata_q      <= wdata_d;
            port_q       <= port_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
`ifndef RF_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign rf_write_en = (state_q == S_ISSUE) && write_q && in_range;
    assign rf_reg_no   = reg_q;
    assign rf_val      = wdata_q;
    assign rsp0_valid  = (state_q == S_RESP) && !port_q;
    assign rsp1_valid  = (state_q == S_RESP) && port_q;
    assign rsp0_rdata  = rsp0_rdata_q;
    assign rsp1_rdata  = rsp1_rdata_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: directed scenarios plus random two-port traffic compared
// against a transaction-level model of arbitration, latency and register contents.
`timescale 1ns/1ps
module tb_reg_file_arbiter;
    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 4;
    localparam int RD_LAT   = 1;
`ifdef RF_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              req0_valid, req0_write, req0_ready, rsp0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_wdata, rsp0_rdata;
    logic              req1_valid, req1_write, req1_ready, rsp1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_wdata, rsp1_rdata;
    logic              rf_write_en, busy;
    logic [ADDR_W-1:0] rf_reg_no;
    logic [DATA_W-1:0] rf_val, rf_dout;

    reg_file_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_reg(req0_reg),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_reg(req1_reg),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata),
        .rf_write_en(rf_write_en), .rf_reg_no(rf_reg_no), .rf_val(rf_val),
        .rf_dout(rf_dout), .busy(busy)
    );

    // Register file stand-in with a registered read (RD_LAT=1); unimplemented slots hold 0xA
    logic [DATA_W-1:0] rf_mem [16];
    logic              rf_init;
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= (i < NUM_REGS) ? DATA_W'(i + 1) : 4'hA;
        end else if (rf_write_en) begin
            rf_mem[rf_reg_no] <= rf_val;
        end
        rf_dout <= rf_mem[rf_reg_no];
    end

    logic [21:0] all_outs;
    assign all_outs = {busy, rf_write_en, rf_reg_no, rf_val, rsp0_valid, rsp1_valid,
                       rsp0_rdata, rsp1_rdata, req0_ready, req1_ready};

    int checks, errors;
    logic [DATA_W-1:0] exp_mem [NUM_REGS];
    int exp_last;
    bit                pv [2];
    bit                pw [2];
    logic [ADDR_W-1:0] pr [2];
    logic [DATA_W-1:0] pd [2];

    function automatic logic [DATA_W-1:0] exp_read(int r);
        if (r < NUM_REGS) return exp_mem[r];
        return '0;
    endfunction

    function automatic int exp_grant(bit v0, bit v1);
        if (v0 && v1) return FIXED ? 0 : 1 - exp_last;
        return v0 ? 0 : 1;
    endfunction

    task automatic model_commit(int g, bit w, int r, logic [DATA_W-1:0] d);
        exp_last = g;
        if (w && r < NUM_REGS) exp_mem[r] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive();
        req0_valid = pv[0]; req0_write = pw[0]; req0_reg = pr[0]; req0_wdata = pd[0];
        req1_valid = pv[1]; req1_write = pw[1]; req1_reg = pr[1]; req1_wdata = pd[1];
    endtask

    task automatic gen_requests();
        for (int p = 0; p < 2; p++) begin
            if (!pv[p] && $urandom_range(0, 2) == 0) begin
                pv[p] = 1'b1;
                pw[p] = 1'($urandom_range(0, 1));
                pr[p] = ADDR_W'($urandom_range(0, 6));
                pd[p] = DATA_W'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rf_init = 1'b1;
        pv = '{1'b0, 1'b0}; drive();
        tick(); tick();
        rf_init = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        rst = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) exp_mem[i] = DATA_W'(i + 1);
        exp_last = 1;
        tick();
    endtask

    task automatic test_write_read();
        pv = '{1'b1, 1'b0}; pw[0] = 1'b1; pr[0] = 4'd2; pd[0] = 4'd10; drive(); #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL wr_accept: ready=%b expected 10", {req0_ready, req1_ready});
        end
        model_commit(0, 1'b1, 2, 4'd10);
        tick(); pv[0] = 1'b0; drive(); #1;
        checks++;
        if ({rf_write_en, rf_reg_no, rf_val, rsp0_valid} !== {1'b1, 4'd2, 4'd10, 1'b0}) begin
            errors++; $display("FAIL wr_issue: we=%b reg=%0d val=%0d rsp0=%b expected 1 2 10 0",
                               rf_write_en, rf_reg_no, rf_val, rsp0_valid);
        end
        tick(); #1;
        checks++;
        if ({rf_write_en, rsp0_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL wr_done: we/rsp0/busy=%b expected 000", {rf_write_en, rsp0_valid, busy});
        end
        pv = '{1'b0, 1'b1}; pw[1] = 1'b0; pr[1] = 4'd2; drive(); #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL rd_accept: ready=%b expected 01", {req0_ready, req1_ready});
        end
        model_commit(1, 1'b0, 2, '0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin pv[1] = 1'b0; drive(); end
            #1;
            checks++;
            if ({rsp1_valid, rsp0_valid} !== {k == 3, 1'b0}) begin
                errors++; $display("FAIL rd_pulse cycle %0d: rsp1/rsp0=%b expected %b0", k,
                                   {rsp1_valid, rsp0_valid}, k == 3);
            end
        end
        checks++;
        if (rsp1_rdata !== exp_read(2)) begin
            errors++; $display("FAIL rd_data: got %0d expected %0d", rsp1_rdata, exp_read(2));
        end
    endtask

    task automatic test_round_robin();
        int g;
        g = 0;
        pv = '{1'b1, 1'b1}; pw = '{1'b1, 1'b1};
        pr[0] = 4'd0; pd[0] = 4'd1; pr[1] = 4'd1; pd[1] = 4'd5; drive();
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i % 2 == 0) begin
                g = exp_grant(1'b1, 1'b1);
                checks++;
                if ({req0_ready, req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rr_grant step %0d: ready=%b expected port %0d", i,
                                       {req0_ready, req1_ready}, g);
                end
                model_commit(g, 1'b1, int'(pr[g]), pd[g]);
            end else begin
                checks++;
                if ({req0_ready, req1_ready, rf_write_en, rf_reg_no, rf_val} !== {3'b001, pr[g], pd[g]}) begin
                    errors++; $display("FAIL rr_issue step %0d: rdy=%b we=%b reg=%0d val=%0d expected 00 1 %0d %0d",
                                       i, {req0_ready, req1_ready}, rf_write_en, rf_reg_no, rf_val, pr[g], pd[g]);
                end
            end
            tick();
        end
        pv = '{1'b0, 1'b0}; drive();
    endtask

    task automatic test_out_of_range();
        pv = '{1'b1, 1'b0}; pw[0] = 1'b1; pr[0] = 4'd7; pd[0] = 4'd3; drive(); #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL oor_write_accept: ready=%b expected 10", {req0_ready, req1_ready});
        end
        model_commit(0, 1'b1, 7, 4'd3);
        tick(); pv[0] = 1'b0; drive(); #1;
        checks++;
        if ({rf_write_en, busy, rf_reg_no} !== {1'b0, 1'b1, 4'd7}) begin
            errors++; $display("FAIL oor_write_dropped: we=%b busy=%b reg=%0d expected 0 1 7",
                               rf_write_en, busy, rf_reg_no);
        end
        tick();
        pv[0] = 1'b1; pw[0] = 1'b0; pr[0] = 4'd7; drive(); #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL oor_read_accept: ready=%b expected 10", {req0_ready, req1_ready});
        end
        model_commit(0, 1'b0, 7, '0);
        tick(); pv[0] = 1'b0; drive();
        tick(); tick(); #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, exp_read(7)}) begin
            errors++; $display("FAIL oor_read_data: rsp0=%b rsp1=%b data=%0d expected 1 0 %0d",
                               rsp0_valid, rsp1_valid, rsp0_rdata, exp_read(7));
        end
        tick();
    endtask

    task automatic test_random();
        int g, n_txn, budget;
        bit w;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d, exp_d, got_d;
        pv = '{1'b0, 1'b0};
        n_txn = 0; budget = 0;
        while (n_txn < 60 && budget < 2000) begin
            budget++;
            gen_requests(); drive(); #1;
            if (!pv[0] && !pv[1]) begin
                checks++;
                if ({req0_ready, req1_ready, busy} !== 3'b000) begin
                    errors++; $display("FAIL rand_idle: rdy/busy=%b expected 000", {req0_ready, req1_ready, busy});
                end
                tick();
                continue;
            end
            g = exp_grant(pv[0], pv[1]);
            checks++;
            if ({req0_ready, req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rand_grant txn %0d: ready=%b expected port %0d", n_txn,
                                   {req0_ready, req1_ready}, g);
            end
            w = pw[g]; r = pr[g]; d = pd[g];
            pv[g] = 1'b0;
            n_txn++;
            model_commit(g, w, int'(r), d);
            tick(); gen_requests(); drive(); #1;
            checks++;
            if ({busy, req0_ready, req1_ready, rf_write_en, rf_reg_no, rf_val} !==
                {3'b100, w && (int'(r) < NUM_REGS), r, d}) begin
                errors++; $display("FAIL rand_issue txn %0d: busy=%b rdy=%b we=%b reg=%0d val=%0d expected we=%b reg=%0d val=%0d",
                                   n_txn, busy, {req0_ready, req1_ready}, rf_write_en, rf_reg_no, rf_val,
                                   w && (int'(r) < NUM_REGS), r, d);
            end
            tick();
            if (!w) begin
                gen_requests(); drive(); #1;
                checks++;
                if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rf_write_en, rf_reg_no} !==
                    {6'b100000, r}) begin
                    errors++; $display("FAIL rand_wait txn %0d: busy=%b rsp=%b rdy=%b we=%b reg=%0d expected reg %0d",
                                       n_txn, busy, {rsp0_valid, rsp1_valid}, {req0_ready, req1_ready},
                                       rf_write_en, rf_reg_no, r);
                end
                tick(); gen_requests(); drive(); #1;
                exp_d = exp_read(int'(r));
                got_d = (g == 0) ? rsp0_rdata : rsp1_rdata;
                checks++;
                if ({rsp0_valid, rsp1_valid} !== ((g == 0) ? 2'b10 : 2'b01) || got_d !== exp_d) begin
                    errors++; $display("FAIL rand_resp txn %0d: rsp=%b data=%0d expected port %0d data %0d",
                                       n_txn, {rsp0_valid, rsp1_valid}, got_d, g, exp_d);
                end
                tick();
            end
        end
        pv = '{1'b0, 1'b0}; drive();
        checks++;
        if (n_txn < 60) begin
            errors++; $display("FAIL rand_budget: completed %0d transactions expected 60", n_txn);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        pv = '{1'b1, 1'b0}; pw[0] = 1'b0; pr[0] = 4'd1; drive(); #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL mid_accept: ready=%b expected 10", {req0_ready, req1_ready});
        end
        tick(); pv[0] = 1'b0; drive();
        tick(); #1;
        checks++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b100) begin
            errors++; $display("FAIL mid_in_wait: busy/rsp=%b expected 100", {busy, rsp0_valid, rsp1_valid});
        end
        rst = 1'b0;
        tick(); #1;
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h expected 0", all_outs);
        end
        rst = 1'b1;
        exp_last = 1;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            checks++;
            if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
                errors++; $display("FAIL mid_no_rsp cycle %0d: busy/rsp=%b expected 000", k,
                                   {busy, rsp0_valid, rsp1_valid});
            end
        end
        pv = '{1'b1, 1'b1}; pw = '{1'b1, 1'b1};
        pr[0] = 4'd3; pd[0] = 4'd4; pr[1] = 4'd3; pd[1] = 4'd9; drive(); #1;
        checks++;
        if ({req0_ready, req1_ready} !== ((exp_grant(1'b1, 1'b1) == 0) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL mid_first_tie: ready=%b expected port %0d", {req0_ready, req1_ready},
                               exp_grant(1'b1, 1'b1));
        end
        model_commit(0, 1'b1, 3, 4'd4);
        tick(); pv = '{1'b0, 1'b0}; drive(); #1;
        checks++;
        if ({rf_write_en, rf_reg_no, rf_val} !== {1'b1, 4'd3, 4'd4}) begin
            errors++; $display("FAIL mid_tie_write: we=%b reg=%0d val=%0d expected 1 3 4",
                               rf_write_en, rf_reg_no, rf_val);
        end
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; rf_init = 1'b0; exp_last = 1;
        pv = '{1'b0, 1'b0}; pw = '{1'b0, 1'b0};
        pr = '{4'd0, 4'd0}; pd = '{4'd0, 4'd0};
        drive();
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
Shares the single-port register file (reg_file: write_en, clk, rst, reg_no, val, dout) between two requesters, e.g. ALU writeback (port 0) and load unit (port 1).
- Accepts read/write requests over valid/ready, arbitrates round-robin and sequences one register-file access at a time.
- Returns read data on a per-port response pulse.
- Sits between the execution units and reg_file; sole driver of reg_file inputs.

Parameters:
DATA_W, 4, register data width
ADDR_W, 4, register index width
NUM_REGS, 4, implemented registers; index >= NUM_REGS is out of range
RD_LAT, 1, cycles from ISSUE edge to valid rf_dout; legal values 0 or 1

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-low
req0_valid  in  1  port 0 request valid
req0_write  in  1  1 = write, 0 = read
req0_reg  in  ADDR_W  register index
req0_wdata  in  DATA_W  write data
req0_ready  out  1  port 0 accepted this cycle
rsp0_valid  out  1  port 0 read response pulse
rsp0_rdata  out  DATA_W  port 0 read data
req1_valid, req1_write, req1_reg, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1
rf_write_en  out  1  to reg_file write_en
rf_reg_no  out  ADDR_W  to reg_file reg_no
rf_val  out  DATA_W  to reg_file val
rf_dout  in  DATA_W  from reg_file dout
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; all outputs 0; last_grant=1, so port 0 wins the first tie.
  - Any in-flight request is dropped and no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational and at most one is high.
  - Only one valid: that port gets ready.
  - Both valid: the port != last_grant gets ready.
  - Transfer on valid&&ready: latch write/reg/wdata/port, update last_grant, go to ISSUE.
  - No valid: stay in IDLE.
- Requester rule: hold the request stable while valid && !ready.
- ISSUE (1 cycle):
  - rf_reg_no=latched reg; rf_val=latched wdata.
  - rf_write_en=1 only for a write with reg < NUM_REGS.
  - Write: go to IDLE. No response.
  - Read, RD_LAT=0: sample rf_dout at the end of ISSUE, go to RESP.
  - Read, RD_LAT=1: go to WAIT.
- WAIT (1 cycle): rf_reg_no is held; sample rf_dout; go to RESP.
- RESP (1 cycle):
  - rspN_valid=1 for the latched port only; rspN_rdata=sampled data.
  - Out-of-range read returns 0.
  - Go to IDLE.
  - No response backpressure.
- Output rules:
  - rspN_rdata holds its last value after the pulse.
  - rf_write_en is 0 in every state except ISSUE.
  - rf_reg_no and rf_val hold their latched values outside ISSUE.
  - No request is accepted outside IDLE, so ready is 0 in ISSUE/WAIT/RESP.
- Latency:
  - Write: accept -> rf write edge = 1 cycle; back-to-back writes every 2 cycles.
  - Read: accept -> rsp_valid = 2 cycles (RD_LAT=0) or 3 cycles (RD_LAT=1).
- Out-of-range index: the request is still accepted and arbitrated normally; the write is dropped and the read returns 0.
- Simultaneous events: a new request arriving while busy waits in valid; last_grant is not updated until acceptance.

Optional Feature:
Macro RF_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins a tie; last_grant is unused. Port 1 can starve.
- Undefined (default): round-robin as above.

Test Plan:
- Reset, then port 0 writes reg 2 = 10 -> req0_ready high in the accept cycle; rf_write_en=1, rf_reg_no=2, rf_val=10 for exactly 1 cycle; no rsp0_valid.
- Port 1 reads reg 2 after that write (RD_LAT=1) -> rsp1_valid one cycle, 3 cycles after accept; rsp1_rdata=10; rsp0_valid stays 0.
- Both ports valid continuously with writes (p0: reg0=1, p1: reg1=5) -> grants alternate p0, p1, p0, p1; accepts every 2 cycles.
- Same traffic with RF_ARB_FIXED_PRIO_EN defined -> only p0 granted while p0 stays valid.
- Port 0 writes reg 7 = 3 (NUM_REGS=4) -> accepted, rf_write_en stays 0; a subsequent read of reg 7 returns rsp0_rdata=0.
- Read accepted, rst driven low during WAIT -> next cycle state=IDLE, busy=0, all outputs 0, no rsp pulse after reset release; port 0 wins the next tie.
